// File: rtl/fbuf_port_arbiter.sv
// Single-port framebuffer arbiter: display scan-out reads beat the deferred
// frame-clear sequencer, which beats the external drawing writer.
module fbuf_port_arbiter #(
  parameter int                    FBUF_ADDR_WIDTH = 8,
  parameter int                    FBUF_WORDS      = 256,
  parameter int                    DATA_WIDTH      = 24,
  parameter int                    MEM_LATENCY     = 1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE     = {DATA_WIDTH{1'b0}}
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       disp_req,
  input  logic [FBUF_ADDR_WIDTH-1:0] disp_addr,
  input  logic                       eof,
  output logic [DATA_WIDTH-1:0]      disp_data,
  output logic                       disp_valid,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [FBUF_ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]      wr_data,
  input  logic                       clr_start,
  output logic                       clr_busy,
  output logic                       clr_done,
  output logic                       mem_en,
  output logic                       mem_we,
  output logic [FBUF_ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]      mem_wdata,
  input  logic [DATA_WIDTH-1:0]      mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_EOF,
    ST_CLEARING
  } state_t;

  // One extra bit so FBUF_WORDS == 2**FBUF_ADDR_WIDTH is representable.
  localparam logic [FBUF_ADDR_WIDTH:0] LP_CLR_LAST = (FBUF_ADDR_WIDTH+1)'(FBUF_WORDS - 1);

  state_t                   r_state;
  state_t                   w_state_next;
  logic [FBUF_ADDR_WIDTH:0] r_clr_cnt;
  logic [FBUF_ADDR_WIDTH:0] w_clr_cnt_next;
  logic [MEM_LATENCY:0]     r_vld_pipe;
  logic                     r_mem_en;
  logic                     r_mem_we;
  logic [FBUF_ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0]    r_mem_wdata;
  logic                     r_clr_busy;
  logic                     r_clr_done;

  logic w_grant_disp;
  logic w_grant_clr;
  logic w_grant_wr;
  logic w_clr_last;
  logic w_wr_ready;

  assign w_grant_disp = disp_req;
  assign w_grant_clr  = (r_state == ST_CLEARING) && !disp_req;
  assign w_wr_ready   = rst_n && (r_state == ST_IDLE) && !disp_req;
  assign w_grant_wr   = wr_valid && w_wr_ready;
  assign w_clr_last   = w_grant_clr && (r_clr_cnt == LP_CLR_LAST);

  always_comb begin
    w_state_next   = r_state;
    w_clr_cnt_next = r_clr_cnt;
    case (r_state)
      ST_IDLE: begin
        if (clr_start) begin
          w_state_next   = eof ? ST_CLEARING : ST_WAIT_EOF;
          w_clr_cnt_next = '0;
        end
      end
      ST_WAIT_EOF: begin
        if (eof) begin
          w_state_next   = ST_CLEARING;
          w_clr_cnt_next = '0;
        end
      end
      ST_CLEARING: begin
        if (w_clr_last) begin
          w_state_next   = ST_IDLE;
          w_clr_cnt_next = '0;
        end else if (w_grant_clr) begin
          w_clr_cnt_next = r_clr_cnt + 1'b1;
        end
      end
      default: begin
        w_state_next   = ST_IDLE;
        w_clr_cnt_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_clr_cnt  <= '0;
      r_clr_busy <= 1'b0;
      r_clr_done <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_clr_cnt  <= w_clr_cnt_next;
      r_clr_busy <= (w_state_next != ST_IDLE);
      r_clr_done <= w_clr_last;
    end
  end

  // Address and data hold on idle cycles; only the strobes drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else if (w_grant_disp) begin
      r_mem_en   <= 1'b1;
      r_mem_we   <= 1'b0;
      r_mem_addr <= disp_addr;
    end else if (w_grant_clr) begin
      r_mem_en    <= 1'b1;
      r_mem_we    <= 1'b1;
      r_mem_addr  <= r_clr_cnt[FBUF_ADDR_WIDTH-1:0];
      r_mem_wdata <= CLEAR_VALUE;
    end else if (w_grant_wr) begin
      r_mem_en    <= 1'b1;
      r_mem_we    <= 1'b1;
      r_mem_addr  <= wr_addr;
      r_mem_wdata <= wr_data;
    end else begin
      r_mem_en <= 1'b0;
      r_mem_we <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_pipe[0] <= 1'b0;
    end else begin
      r_vld_pipe[0] <= disp_req;
    end
  end

  // Remaining stages cover the BRAM read latency.
  for (genvar gi = 1; gi <= MEM_LATENCY; gi++) begin : g_vld_pipe
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_vld_pipe[gi] <= 1'b0;
      end else begin
        r_vld_pipe[gi] <= r_vld_pipe[gi-1];
      end
    end
  end

  assign disp_data  = mem_rdata;
  assign disp_valid = r_vld_pipe[MEM_LATENCY];
  assign wr_ready   = w_wr_ready;
  assign clr_busy   = r_clr_busy;
  assign clr_done   = r_clr_done;
  assign mem_en     = r_mem_en;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_fbuf_port_arbiter.sv
// Directed bench for fbuf_port_arbiter with a 1-cycle-latency BRAM model.
module tb_fbuf_port_arbiter;

  localparam int AW = 8;
  localparam int DW = 24;
  localparam int NW = 256;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          disp_req = 1'b0;
  logic [AW-1:0] disp_addr = '0;
  logic          eof = 1'b0;
  logic [DW-1:0] disp_data;
  logic          disp_valid;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          clr_start = 1'b0;
  logic          clr_busy;
  logic          clr_done;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  logic [DW-1:0] bram [0:NW-1];

  int n_tests = 0;
  int n_fail  = 0;

  fbuf_port_arbiter #(
    .FBUF_ADDR_WIDTH(AW),
    .FBUF_WORDS     (NW),
    .DATA_WIDTH     (DW),
    .MEM_LATENCY    (1),
    .CLEAR_VALUE    (24'h000000)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .disp_req  (disp_req),
    .disp_addr (disp_addr),
    .eof       (eof),
    .disp_data (disp_data),
    .disp_valid(disp_valid),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .clr_start (clr_start),
    .clr_busy  (clr_busy),
    .clr_done  (clr_done),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) bram[mem_addr] <= mem_wdata;
      else        mem_rdata <= bram[mem_addr];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic prefill();
    for (int i = 0; i < NW; i++) bram[i] <= 24'hA00000 | 24'(i);
    #1;
  endtask

  task automatic test_reset();
    wr_valid = 1'b1; wr_addr = 8'h03; wr_data = 24'h000001;
    #2 rst_n = 1'b0;
    step(); step();
    n_tests++;
    if (mem_en !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 8'h00 || mem_wdata !== 24'h0) begin
      n_fail++;
      $display("FAIL reset_mem: en=%b we=%b addr=%h wdata=%h, required 0/0/00/000000", mem_en, mem_we, mem_addr, mem_wdata);
    end
    n_tests++;
    if (disp_valid !== 1'b0 || clr_busy !== 1'b0 || clr_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_status: valid=%b busy=%b done=%b, required 0/0/0", disp_valid, clr_busy, clr_done);
    end
    n_tests++;
    if (wr_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_wr_ready: got %b, required 0", wr_ready);
    end
    wr_valid = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    step();
    $display("[TB] reset checked");
  endtask

  task automatic test_display_read();
    prefill();
    disp_req = 1'b1; disp_addr = 8'h12;
    step();
    disp_req = 1'b0;
    n_tests++;
    if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 8'h12) begin
      n_fail++;
      $display("FAIL disp_read_issue: en=%b we=%b addr=%h, required 1/0/12", mem_en, mem_we, mem_addr);
    end
    n_tests++;
    if (disp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL disp_valid_early: got %b, required 0", disp_valid);
    end
    step();
    n_tests++;
    if (disp_valid !== 1'b1 || disp_data !== 24'hA00012) begin
      n_fail++;
      $display("FAIL disp_data: valid=%b data=%h, required 1/a00012", disp_valid, disp_data);
    end
    step();
    n_tests++;
    if (disp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL disp_valid_end: got %b, required 0", disp_valid);
    end
    $display("[TB] display read addr=12 data=%h", 24'hA00012);
  endtask

  task automatic test_write_collision();
    int bad = 0;
    wr_valid = 1'b1; wr_addr = 8'h05; wr_data = 24'hABCDEF;
    for (int i = 0; i < 3; i++) begin
      disp_req = 1'b1; disp_addr = 8'h20 + 8'(i);
      #1;
      if (wr_ready !== 1'b0) bad++;
      step();
      if (mem_we !== 1'b0) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL wr_blocked: %0d violations, required 0", bad);
    end
    disp_req = 1'b0;
    #1;
    n_tests++;
    if (wr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL wr_ready_free: got %b, required 1", wr_ready);
    end
    step();
    wr_valid = 1'b0;
    n_tests++;
    if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 8'h05 || mem_wdata !== 24'hABCDEF) begin
      n_fail++;
      $display("FAIL wr_issue: en=%b we=%b addr=%h wdata=%h, required 1/1/05/abcdef", mem_en, mem_we, mem_addr, mem_wdata);
    end
    step();
    n_tests++;
    if (bram[5] !== 24'hABCDEF) begin
      n_fail++;
      $display("FAIL wr_commit: bram[05]=%h, required abcdef", bram[5]);
    end
    $display("[TB] collided write addr=05 data=abcdef");
  endtask

  task automatic test_eof_ignored();
    eof = 1'b1;
    step();
    eof = 1'b0;
    n_tests++;
    if (clr_busy !== 1'b0 || mem_en !== 1'b0) begin
      n_fail++;
      $display("FAIL eof_ignored: busy=%b en=%b, required 0/0", clr_busy, mem_en);
    end
    $display("[TB] stray eof in idle");
  endtask

  task automatic test_deferred_clear();
    int bad = 0;
    int idx = 0;
    int done_cnt = 0;
    int cyc = 0;
    prefill();
    clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    n_tests++;
    if (clr_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_busy_rise: got %b, required 1", clr_busy);
    end
    wr_valid = 1'b1; wr_addr = 8'h07; wr_data = 24'h55AA55;
    for (int i = 0; i < 9; i++) begin
      clr_start = (i == 3);
      #1;
      if (wr_ready !== 1'b0) bad++;
      step();
      if (mem_en !== 1'b0 || clr_busy !== 1'b1) bad++;
    end
    clr_start = 1'b0;
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL clr_wait: %0d violations before eof, required 0", bad);
    end
    eof = 1'b1;
    step();
    eof = 1'b0;
    bad = 0;
    while (done_cnt == 0 && cyc < 400) begin
      step();
      cyc++;
      if (mem_en === 1'b1 && mem_we === 1'b1) begin
        if (mem_addr !== 8'(idx) || mem_wdata !== 24'h0) bad++;
        if (idx == 0 && cyc != 1) bad++;
        idx++;
      end else begin
        bad++;
      end
      if (clr_done === 1'b1) begin
        done_cnt++;
        if (clr_busy !== 1'b0) bad++;
      end else if (clr_busy !== 1'b1) begin
        bad++;
      end
    end
    n_tests++;
    if (done_cnt != 1) begin
      n_fail++;
      $display("FAIL clr_done_seen: got %0d pulses within %0d cycles, required 1", done_cnt, cyc);
    end
    n_tests++;
    if (idx != NW) begin
      n_fail++;
      $display("FAIL clr_count: %0d clear writes, required %0d", idx, NW);
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL clr_order: %0d sequence violations, required 0", bad);
    end
    n_tests++;
    if (wr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL wr_after_clear: wr_ready=%b, required 1", wr_ready);
    end
    step();
    wr_valid = 1'b0;
    n_tests++;
    if (clr_done !== 1'b0 || mem_we !== 1'b1 || mem_addr !== 8'h07 || mem_wdata !== 24'h55AA55) begin
      n_fail++;
      $display("FAIL wr_after_clear_issue: done=%b we=%b addr=%h wdata=%h, required 0/1/07/55aa55", clr_done, mem_we, mem_addr, mem_wdata);
    end
    step();
    bad = 0;
    for (int i = 0; i < NW; i++) begin
      if (bram[i] !== ((i == 7) ? 24'h55AA55 : 24'h0)) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL clr_content: %0d words wrong, required 0", bad);
    end
    $display("[TB] deferred clear: %0d writes, %0d clr_done pulses", idx, done_cnt);
  endtask

  task automatic test_clear_interleaved();
    int bad = 0;
    int vbad = 0;
    int idx = 0;
    int cyc = 0;
    logic done = 1'b0;
    logic req_now;
    logic req_prev = 1'b0;
    logic [AW-1:0] addr_now;
    prefill();
    clr_start = 1'b1; eof = 1'b1;
    step();
    clr_start = 1'b0; eof = 1'b0;
    n_tests++;
    if (clr_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_direct_busy: got %b, required 1", clr_busy);
    end
    while (!done && cyc < 800) begin
      req_now  = (cyc % 2 == 0);
      addr_now = 8'(cyc * 7);
      disp_req = req_now; disp_addr = addr_now;
      step();
      if (req_now) begin
        if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== addr_now) bad++;
      end else if (idx < NW) begin
        if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 8'(idx) || mem_wdata !== 24'h0) bad++;
        idx++;
      end else if (mem_en !== 1'b0) begin
        bad++;
      end
      if (cyc >= 1 && disp_valid !== req_prev) vbad++;
      req_prev = req_now;
      if (clr_done === 1'b1) done = 1'b1;
      cyc++;
    end
    disp_req = 1'b0;
    n_tests++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL ilv_done: no clr_done within %0d cycles", cyc);
    end
    n_tests++;
    if (bad != 0 || idx != NW) begin
      n_fail++;
      $display("FAIL ilv_bus: %0d bus violations, %0d clear writes, required 0 and %0d", bad, idx, NW);
    end
    n_tests++;
    if (vbad != 0) begin
      n_fail++;
      $display("FAIL ilv_disp_valid: %0d latency violations, required 0", vbad);
    end
    step();
    bad = 0;
    for (int i = 0; i < NW; i++) if (bram[i] !== 24'h0) bad++;
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL ilv_content: %0d words not cleared, required 0", bad);
    end
    $display("[TB] interleaved clear: %0d cycles, %0d writes", cyc, idx);
  endtask

  task automatic test_reset_mid_clear();
    int bad = 0;
    int idx = 0;
    int cyc = 0;
    int done_cnt = 0;
    prefill();
    clr_start = 1'b1; eof = 1'b1;
    step();
    clr_start = 1'b0; eof = 1'b0;
    while (idx < 100 && cyc < 200) begin
      step();
      cyc++;
      if (mem_en === 1'b1 && mem_we === 1'b1) idx++;
    end
    n_tests++;
    if (idx != 100) begin
      n_fail++;
      $display("FAIL rst_mid_progress: %0d writes, required 100", idx);
    end
    // A display cycle lets the 100th write land in the BRAM before reset.
    disp_req = 1'b1; disp_addr = 8'h00;
    step();
    disp_req = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (clr_busy !== 1'b0 || mem_en !== 1'b0 || clr_done !== 1'b0 || wr_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: busy=%b en=%b done=%b ready=%b, required 0/0/0/0", clr_busy, mem_en, clr_done, wr_ready);
    end
    step(); if (clr_done !== 1'b0) bad++;
    step(); if (clr_done !== 1'b0) bad++;
    @(negedge clk) rst_n = 1'b1;
    step();
    if (clr_done !== 1'b0 || clr_busy !== 1'b0 || mem_en !== 1'b0) bad++;
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL rst_mid_no_done: %0d violations after reset, required 0", bad);
    end
    bad = 0;
    for (int i = 0; i < NW; i++) begin
      if (bram[i] !== ((i < 100) ? 24'h0 : (24'hA00000 | 24'(i)))) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL rst_mid_partial: %0d words wrong, required 0", bad);
    end
    clr_start = 1'b1; eof = 1'b1;
    step();
    clr_start = 1'b0; eof = 1'b0;
    idx = 0; cyc = 0; bad = 0;
    while (done_cnt == 0 && cyc < 400) begin
      step();
      cyc++;
      if (mem_en === 1'b1 && mem_we === 1'b1) begin
        if (mem_addr !== 8'(idx) || mem_wdata !== 24'h0) bad++;
        idx++;
      end else begin
        bad++;
      end
      if (clr_done === 1'b1) done_cnt++;
    end
    n_tests++;
    if (done_cnt != 1 || idx != NW || bad != 0) begin
      n_fail++;
      $display("FAIL reclear: done=%0d writes=%0d violations=%0d, required 1/%0d/0", done_cnt, idx, bad, NW);
    end
    step();
    bad = 0;
    for (int i = 0; i < NW; i++) if (bram[i] !== 24'h0) bad++;
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL reclear_content: %0d words not cleared, required 0", bad);
    end
    $display("[TB] reset mid-clear then full reclear: %0d writes", idx);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_display_read();
    test_write_collision();
    test_eof_ignored();
    test_deferred_clear();
    test_clear_interleaved();
    test_reset_mid_clear();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
